// File: rtl/mem_block_copier_if.sv
// mem_block_copier_if: control handshake and data-port bus of the block copier
interface mem_block_copier_if #(parameter int WIDTH = 32, parameter int LENWIDTH = 12);
  logic                start;
  logic [WIDTH-1:0]    src;
  logic [WIDTH-1:0]    dst;
  logic [LENWIDTH-1:0] len;
  logic                busy;
  logic                done;
  logic                err;
  logic [LENWIDTH-1:0] count;
  logic [WIDTH-1:0]    mem_a;
  logic [WIDTH-1:0]    mem_wd;
  logic                mem_we;
  logic [WIDTH-1:0]    mem_rd;
  modport master (
    input  start, src, dst, len, mem_rd,
    output busy, done, err, count, mem_a, mem_wd, mem_we
  );
  modport slave (
    output start, src, dst, len, mem_rd,
    input  busy, done, err, count, mem_a, mem_wd, mem_we
  );
endinterface

// File: rtl/mem_block_copier.sv
// mem_block_copier: copies len words from src to dst over the segmented data port
module mem_block_copier #(
  parameter int WIDTH    = 32,
  parameter int RAMSIZE  = 512,
  parameter int NSEG     = 6,
  parameter int LENWIDTH = 12
) (
  input logic               clk,
  input logic               reset,
  mem_block_copier_if.master bus
);
  typedef enum logic [2:0] {IDLE, CHECK, READ, LATCH, WRITE, DONE} state_t;
  localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(NSEG * RAMSIZE);
  state_t              state_q, state_d;
  logic [WIDTH-1:0]    src_q, src_d, dst_q, dst_d, data_q, data_d;
  logic [LENWIDTH-1:0] len_q, len_d, count_q, count_d;
  logic                err_q, err_d;
  logic [WIDTH:0]      src_end, dst_end;
  assign src_end = {1'b0, src_q} + (WIDTH+1)'(len_q);
  assign dst_end = {1'b0, dst_q} + (WIDTH+1)'(len_q);
  // next-state: request capture, range check, read/latch/write word loop
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    count_d = count_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (bus.start) begin
        src_d   = bus.src;
        dst_d   = bus.dst;
        len_d   = bus.len;
        count_d = '0;
        state_d = CHECK;
      end
      CHECK: begin
        err_d   = (src_end > LIMIT) || (dst_end > LIMIT);
        state_d = (err_d || len_q == '0) ? DONE : READ;
      end
      READ:  state_d = LATCH;
      LATCH: begin
        data_d  = bus.mem_rd;
        state_d = WRITE;
      end
      WRITE: begin
        count_d = count_q + LENWIDTH'(1);
        state_d = (count_d == len_q) ? DONE : READ;
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and operand registers; async reset abandons any copy in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      count_q <= count_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end
  // outputs decode from registered state so reset clears them without a clock
  always_comb begin
    bus.busy   = state_q != IDLE;
    bus.done   = state_q == DONE;
    bus.err    = (state_q == DONE) && err_q;
    bus.count  = count_q;
    bus.mem_we = state_q == WRITE;
    bus.mem_wd = (state_q == WRITE) ? data_q : '0;
    bus.mem_a  = (state_q == READ || state_q == LATCH) ? src_q + WIDTH'(count_q) :
                 (state_q == WRITE) ? dst_q + WIDTH'(count_q) : '0;
  end
endmodule

// File: tb/tb_mem_block_copier.sv
// tb_mem_block_copier: scoreboard bench for the block copier against a 3072-word memory
module tb_mem_block_copier;
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_mem = 1'b1;
  logic [31:0] mem [3072];
  logic [31:0] ref_mem [3072];
  wr_t         exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_wr = 0;
  always #5 clk = ~clk;
  mem_block_copier_if bus();
  mem_block_copier dut (.clk(clk), .reset(reset), .bus(bus));
  function automatic logic [31:0] init_val(input int i);
    if (i >= 100 && i <= 103) return 32'(32'hA0 + i - 100);
    if (i >= 10 && i <= 13) return 32'(i - 9);
    return 32'(32'h5000_0000 + i);
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 3072; i++) mem[i] <= init_val(i);
    end else begin
      if (bus.mem_we && bus.mem_a < 3072) mem[bus.mem_a[11:0]] <= bus.mem_wd;
      bus.mem_rd <= (bus.mem_a < 3072) ? mem[bus.mem_a[11:0]] : 32'hDEAD_BEEF;
    end
  end
  always @(negedge clk) begin
    wr_t e;
    if (bus.mem_we) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        chk("wr_extra", {32'b0, bus.mem_a}, 64'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {32'b0, bus.mem_a}, {32'b0, e.a});
        chk("wr_data", {32'b0, bus.mem_wd}, {32'b0, e.d});
      end
    end
  end
  task automatic drive_start(input logic [31:0] s, input logic [31:0] d, input logic [11:0] l);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.src   = s;
    bus.dst   = d;
    bus.len   = l;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [11:0] l, input bit mid_start);
    int  lat = 0;
    int  busy_n = 0;
    int  w0;
    int  exp_lat;
    bit  ok;
    wr_t e;
    ok = (longint'(s) + l <= 3072) && (longint'(d) + l <= 3072);
    exp_lat = ok ? 2 + 3 * int'(l) : 2;
    if (ok) begin
      for (int i = 0; i < int'(l); i++) begin
        e.a = d + i;
        e.d = ref_mem[s + i];
        ref_mem[d + i] = e.d;
        exp_q.push_back(e);
      end
    end
    w0 = n_wr;
    drive_start(s, d, l);
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_n++;
      if (mid_start && lat == 4) begin
        bus.start = 1'b1;
        bus.src   = 32'd0;
        bus.dst   = 32'd2000;
        bus.len   = 12'd1;
      end
      if (mid_start && lat == 5) bus.start = 1'b0;
      if (bus.done) break;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_cycles", 64'(busy_n), 64'(exp_lat));
    chk("err", {63'b0, bus.err}, {63'b0, !ok});
    chk("count_done", {52'b0, bus.count}, ok ? {52'b0, l} : 64'd0);
    bus.start = 1'b1;
    bus.src   = 32'd0;
    bus.dst   = 32'd2000;
    bus.len   = 12'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_after", {63'b0, bus.busy}, 64'd0);
    chk("count_hold", {52'b0, bus.count}, ok ? {52'b0, l} : 64'd0);
    chk("writes", 64'(n_wr - w0), ok ? {52'b0, l} : 64'd0);
    chk("queue_left", 64'(exp_q.size()), 64'd0);
  endtask
  initial begin
    int  cyc;
    int  bad;
    wr_t e;
    bus.start = 1'b0;
    bus.src   = '0;
    bus.dst   = '0;
    bus.len   = '0;
    for (int i = 0; i < 3072; i++) ref_mem[i] = init_val(i);
    #1;
    chk("rst0_ctl", {48'b0, bus.busy, bus.done, bus.err, bus.mem_we, bus.count}, 64'd0);
    chk("rst0_a", {32'b0, bus.mem_a}, 64'd0);
    chk("rst0_wd", {32'b0, bus.mem_wd}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    init_mem = 1'b0;
    reset = 1'b0;
    run_copy(32'd100, 32'd600, 12'd4, 1'b0);
    chk("t1_603", {32'b0, mem[603]}, 64'hA3);
    run_copy(32'd5, 32'd7, 12'd0, 1'b0);
    run_copy(32'd3070, 32'd0, 12'd4, 1'b0);
    run_copy(32'd0, 32'd3071, 12'd2, 1'b0);
    run_copy(32'd510, 32'd1020, 12'd4, 1'b0);
    run_copy(32'd10, 32'd11, 12'd3, 1'b1);
    chk("t5_13", {32'b0, mem[13]}, 64'd1);
    for (int i = 0; i < 2; i++) begin
      e.a = 32'(700 + i);
      e.d = ref_mem[200 + i];
      exp_q.push_back(e);
    end
    ref_mem[700] = ref_mem[200];
    drive_start(32'd200, 32'd700, 12'd4);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_we && bus.count == 12'd1) break;
    end
    chk("rst_reach", 64'(cyc < 100), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_ctl", {48'b0, bus.busy, bus.done, bus.err, bus.mem_we, bus.count}, 64'd0);
    chk("rst_a", {32'b0, bus.mem_a}, 64'd0);
    chk("rst_wd", {32'b0, bus.mem_wd}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mem700", {32'b0, mem[700]}, {32'b0, ref_mem[700]});
    chk("rst_mem701", {32'b0, mem[701]}, {32'b0, ref_mem[701]});
    chk("rst_queue", 64'(exp_q.size()), 64'd0);
    run_copy(32'd300, 32'd900, 12'd5, 1'b0);
    @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 3072; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", 64'(bad), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_block_copier.md
Name: mem_block_copier

Overview:
- Bus initiator that drives the data-segment port of the segmented memory: data address, write data, write enable and read data.
- Copies a block of `len` consecutive words from `src` to `dst` inside the 6-segment data space.
- Started by the control path with a start/busy/done handshake. The pipeline holds its own data-port accesses while `busy` is high.

Parameters:
- WIDTH, 32, data and address width in bits.
- RAMSIZE, 512, words per data segment.
- NSEG, 6, number of data segments; the valid data space is 0 .. NSEG*RAMSIZE-1.
- LENWIDTH, 12, width of the length operand and of the word counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src  in  WIDTH  source word address; sampled with start.
- dst  in  WIDTH  destination word address; sampled with start.
- len  in  LENWIDTH  number of words to copy; sampled with start.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse marking the end of the operation.
- err  out  1  one-cycle pulse coincident with done when the request was rejected.
- count  out  LENWIDTH  number of words written so far in the current operation.
- mem_a  out  WIDTH  data-port address.
- mem_wd  out  WIDTH  data-port write data.
- mem_we  out  1  data-port write enable.
- mem_rd  in  WIDTH  data-port read data; valid the cycle after mem_a is presented with mem_we=0.

Behaviour:
- Reset (asynchronous, any state): state=IDLE and every output goes to 0 (busy, done, err, count, mem_a, mem_wd, mem_we). Internal src/dst/len/data registers go to 0.
- Reset in mid-operation: words already written stay in memory; no further accesses are issued.
- States: IDLE, CHECK, READ, LATCH, WRITE, DONE.
- IDLE:
  - mem_we=0.
  - On start=1: register src, dst and len; clear count; go to CHECK.
- CHECK (1 cycle, busy=1, no memory access):
  - If src+len > NSEG*RAMSIZE or dst+len > NSEG*RAMSIZE: set the error flag and go to DONE. Compare in WIDTH+1 bits so overflow cannot wrap.
  - Else if len==0: go to DONE with no error.
  - Else: go to READ.
- READ: mem_a=src+count, mem_we=0. Go to LATCH.
- LATCH:
  - mem_a holds src+count, mem_we=0.
  - mem_rd is captured into the data register at the end of the cycle. Go to WRITE.
- WRITE:
  - mem_a=dst+count, mem_wd=data register, mem_we=1 for exactly this cycle.
  - count increments at the end of the cycle.
  - If the new count==len, go to DONE; else go to READ.
- DONE (1 cycle): done=1, err=error flag, busy=1. Then go to IDLE with busy=0; the error flag clears on entering IDLE.
- Latency: an accepted start to the done pulse takes 2 + 3*len cycles. A rejected or zero-length request takes 2 cycles.
- Throughput: exactly one memory write per 3 cycles. mem_we is never asserted outside WRITE.
- start asserted while busy is ignored, including during the DONE cycle. A new start is accepted in the first IDLE cycle after done.
- Overlap: copying is strictly ascending, word by word.
  - If dst > src and the ranges overlap, source words are overwritten before they are read. The result is the defined forward-copy pattern (replication).
  - If dst == src, memory is rewritten with the same values.
- Address arithmetic is unsigned, WIDTH bits. A segment crossing within the range is legal and transparent (e.g. src=510, len=4 spans segments 0 and 1).
- count holds its final value after done until the next accepted start.

Test Plan:
1. Preload words 100..103 with A0,A1,A2,A3. Request start, src=100, dst=600, len=4. → busy for 14 cycles. done pulses 14 cycles after start with err=0. Exactly 4 write cycles, at addresses 600..603 with data A0..A3. count=4.
2. Request len=0, src=5, dst=7. → done and err=0 two cycles after start. mem_we never asserted. count=0.
3. Request src=3070, dst=0, len=4 (3070+4 > 3072). → done with err=1 two cycles after start, no accesses. Repeat with dst=3071, len=2 → err=1.
4. Copy across a segment boundary: src=510, len=4, dst=1020 (straddles segments 1/2). → words 510..513 appear at 1020..1023.
5. Overlap: memory 10..13 = 1,2,3,4. Request src=10, dst=11, len=3. → 11..13 = 1,1,1. A second start pulsed mid-operation is ignored.
6. Assert reset during the second WRITE of a len=4 copy. → All outputs are 0 immediately, without waiting for a clock edge, and exactly 1 word has been written. The next start is accepted normally.
